mem_sequencer: RTL

- Multicycle control sequencer that sits directly upstream of the unified system memory (16-bit instruction ROM plus 8-bit data RAM behind a 2:1 output mux).
- Drives the memory's address, write data, output selector and write enable, and consumes its 16-bit output.
- Fetches instructions from ROM and executes a minimal load/store/jump instruction set against the data RAM through one 8-bit accumulator.
- Serves as the fetch/control core that closes the loop around the memory block.

---
 rtl/mem_sequencer.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/mem_sequencer.sv
// mem_sequencer
// Multicycle fetch/execute sequencer for the unified system memory
// (16-bit instruction ROM plus 8-bit data RAM behind a 2:1 output mux).
// It runs a minimal load/store/jump instruction set through one accumulator.
//
// Ports:
//   clk            system clock, rising edge
//   reset          asynchronous, active-high reset
//   start          level; leaves IDLE when sampled high (ignored elsewhere)
//   mem_q          memory output; RAM reads arrive zero-extended in the low byte
//   mem_addr       memory address
//   mem_data       memory write data (always the accumulator)
//   mem_q_selector 0 = instruction ROM, 1 = data RAM
//   mem_we         RAM write enable (one cycle, STORE only)
//   pc, ir, acc    architectural registers
//   busy           high in FETCH, DECODE, LOAD_CAP and STORE
//   halted         high in HALT
module mem_sequencer #(
  parameter int DATA_INS_WIDTH = 16,
  parameter int DATA_DAT_WIDTH = 8,   // must be <= 12
  parameter int ADDR_WIDTH     = 6    // must be <= 12
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [DATA_INS_WIDTH-1:0] mem_q,
  output logic [ADDR_WIDTH-1:0]     mem_addr,
  output logic [DATA_DAT_WIDTH-1:0] mem_data,
  output logic                      mem_q_selector,
  output logic                      mem_we,
  output logic [ADDR_WIDTH-1:0]     pc,
  output logic [DATA_INS_WIDTH-1:0] ir,
  output logic [DATA_DAT_WIDTH-1:0] acc,
  output logic                      busy,
  output logic                      halted
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_LOAD_CAP,
    S_STORE,
    S_HALT
  } state_t;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_LDI  = 4'h1;
  localparam logic [3:0] OP_LD   = 4'h2;
  localparam logic [3:0] OP_ST   = 4'h3;
  localparam logic [3:0] OP_JMP  = 4'h4;
  localparam logic [3:0] OP_ADDI = 4'h5;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam logic [ADDR_WIDTH-1:0] PC_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  state_t                    state_reg, state_next;
  logic [ADDR_WIDTH-1:0]     pc_reg, pc_next;
  logic [DATA_INS_WIDTH-1:0] ir_reg, ir_next;
  logic [DATA_DAT_WIDTH-1:0] acc_reg, acc_next;

  logic [3:0]                opcode;
  logic [ADDR_WIDTH-1:0]     op_addr;
  logic [DATA_DAT_WIDTH-1:0] imm;

  assign opcode  = ir_reg[DATA_INS_WIDTH-1 -: 4];
  assign op_addr = ir_reg[ADDR_WIDTH-1:0];
  assign imm     = ir_reg[DATA_DAT_WIDTH-1:0];

  assign pc       = pc_reg;
  assign ir       = ir_reg;
  assign acc      = acc_reg;
  assign mem_data = acc_reg;

  // Because every memory-side output is decoded from state_reg, the async
  // reset clears mem_we in the same cycle it is asserted, even mid-STORE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= S_IDLE;
      pc_reg    <= '0;
      ir_reg    <= '0;
      acc_reg   <= '0;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
      ir_reg    <= ir_next;
      acc_reg   <= acc_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    pc_next        = pc_reg;
    ir_next        = ir_reg;
    acc_next       = acc_reg;
    mem_addr       = pc_reg;
    mem_q_selector = 1'b0;
    mem_we         = 1'b0;
    busy           = 1'b0;
    halted         = 1'b0;

    case (state_reg)
      S_IDLE: begin
        if (start) state_next = S_FETCH;
      end

      S_FETCH: begin
        busy       = 1'b1;
        ir_next    = mem_q;
        pc_next    = pc_reg + PC_ONE;  // wraps naturally at the top address
        state_next = S_DECODE;
      end

      // Presenting the operand address here lets the RAM register it on this
      // edge, so LOAD_CAP sees valid data and STORE can write straight away.
      S_DECODE: begin
        busy           = 1'b1;
        mem_addr       = op_addr;
        mem_q_selector = 1'b1;
        state_next     = S_FETCH;
        case (opcode)
          OP_LDI:  acc_next   = imm;
          OP_LD:   state_next = S_LOAD_CAP;
          OP_ST:   state_next = S_STORE;
          OP_JMP:  pc_next    = op_addr;
          OP_ADDI: acc_next   = acc_reg + imm;  // carry discarded
          OP_HALT: state_next = S_HALT;
          OP_NOP:  state_next = S_FETCH;
          default: state_next = S_FETCH;       // unknown opcodes act as NOP
        endcase
      end

      S_LOAD_CAP: begin
        busy           = 1'b1;
        mem_addr       = op_addr;
        mem_q_selector = 1'b1;
        acc_next       = mem_q[DATA_DAT_WIDTH-1:0];
        state_next     = S_FETCH;
      end

      S_STORE: begin
        busy           = 1'b1;
        mem_addr       = op_addr;
        mem_q_selector = 1'b1;
        mem_we         = 1'b1;
        state_next     = S_FETCH;
      end

      S_HALT: begin
        halted = 1'b1;  // sticky until reset
      end

      default: state_next = S_IDLE;
    endcase
  end

endmodule
